// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared opcode/funct encodings, ALU operation enum, decoded
//                control bundle and immediate sign-extension helper for the
//                single-cycle MIPS core.
//  Revision    : 1.0  initial release
// ============================================================================
package mips_pkg;

   // Primary opcodes (instr[31:26])
   localparam logic [5:0] c_OP_RTYPE = 6'b000000;
   localparam logic [5:0] c_OP_ADDI  = 6'b001000;
   localparam logic [5:0] c_OP_LW    = 6'b100011;
   localparam logic [5:0] c_OP_SW    = 6'b101011;
   localparam logic [5:0] c_OP_BEQ   = 6'b000100;
   localparam logic [5:0] c_OP_J     = 6'b000010;

   // R-type function codes (instr[5:0])
   localparam logic [5:0] c_FN_ADD   = 6'b100000;
   localparam logic [5:0] c_FN_SUB   = 6'b100010;
   localparam logic [5:0] c_FN_AND   = 6'b100100;
   localparam logic [5:0] c_FN_OR    = 6'b100101;
   localparam logic [5:0] c_FN_SLT   = 6'b101010;

   typedef enum logic [2:0] {
      ALU_ADD = 3'd0,
      ALU_SUB = 3'd1,
      ALU_AND = 3'd2,
      ALU_OR  = 3'd3,
      ALU_SLT = 3'd4
   } alu_op_t;

   typedef struct packed {
      logic    reg_write;   // commit a register-file write
      logic    reg_dst;     // 1: destination is rd, 0: rt
      logic    alu_src;     // 1: ALU B operand is the sign-extended immediate
      logic    mem_write;   // store to data memory
      logic    mem_to_reg;  // writeback value comes from data memory
      logic    branch;      // beq
      logic    jump;        // j
      alu_op_t alu_op;
   } ctrl_t;

   function automatic logic [31:0] sign_extend(input logic [15:0] imm);
      return {{16{imm[15]}}, imm};
   endfunction

endpackage
`default_nettype wire

// File: rtl/mips_processor_core_units.sv
`default_nettype none
// ============================================================================
//  Module      : instr_mem, reg_file, data_mem, control, alu
//  Description : Building blocks of the single-cycle MIPS core.
//    instr_mem : word-addressed ROM-style store, combinational read.
//                Ports: clk, i_we/i_waddr/i_wdata (load port), i_addr, o_data
//    reg_file  : 32x32 registers, 2 combinational reads, 1 sync write.
//                Ports: clk, rst, i_ra1, i_ra2, o_rd1, o_rd2, i_we, i_wa, i_wd
//    data_mem  : word-addressed RAM, combinational read, sync write.
//                Ports: clk, rst, i_we, i_addr, i_wdata, o_rdata
//    control   : opcode/funct decode into ctrl_t.
//                Ports: i_opcode, i_funct, o_ctrl
//    alu       : 32-bit ADD/SUB/AND/OR/SLT with zero flag.
//                Ports: i_a, i_b, i_op, o_y, o_zero
//  Revision    : 1.0  initial release
// ============================================================================

module instr_mem #(
   parameter int WORDS = 1024
) (
   input  logic        clk,
   input  logic        i_we,
   input  logic [9:0]  i_waddr,
   input  logic [31:0] i_wdata,
   input  logic [9:0]  i_addr,
   output logic [31:0] o_data
);
   logic [31:0] mem [0:WORDS-1];

   // Load port exists so the array has a legal driver; the core ties it off
   // and programs are normally placed here through hierarchy.
   always_ff @(posedge clk) begin
      if (i_we) mem[i_waddr] <= i_wdata;
   end

   assign o_data = mem[i_addr];
endmodule

module reg_file (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  i_ra1,
   input  logic [4:0]  i_ra2,
   output logic [31:0] o_rd1,
   output logic [31:0] o_rd2,
   input  logic        i_we,
   input  logic [4:0]  i_wa,
   input  logic [31:0] i_wd
);
   logic [31:0] regs [0:31];

   // Contents are deliberately not cleared by reset; reset only blocks writes.
   always_ff @(posedge clk) begin
      if (!rst && i_we && (i_wa != 5'd0)) regs[i_wa] <= i_wd;
   end

   // $0 reads as zero regardless of what the storage word holds.
   assign o_rd1 = (i_ra1 == 5'd0) ? 32'd0 : regs[i_ra1];
   assign o_rd2 = (i_ra2 == 5'd0) ? 32'd0 : regs[i_ra2];
endmodule

module data_mem #(
   parameter int WORDS = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_we,
   input  logic [9:0]  i_addr,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_rdata
);
   logic [31:0] mem [0:WORDS-1];

   always_ff @(posedge clk) begin
      if (!rst && i_we) mem[i_addr] <= i_wdata;
   end

   assign o_rdata = mem[i_addr];
endmodule

module control
   import mips_pkg::*;
(
   input  logic [5:0] i_opcode,
   input  logic [5:0] i_funct,
   output ctrl_t      o_ctrl
);
   // Anything not decoded below leaves every control bit low, so unknown
   // opcodes and functs behave as a nop that simply advances the pc.
   always_comb begin
      o_ctrl        = '0;
      o_ctrl.alu_op = ALU_ADD;
      case (i_opcode)
         c_OP_RTYPE: begin
            case (i_funct)
               c_FN_ADD: begin o_ctrl.reg_write = 1'b1; o_ctrl.reg_dst = 1'b1; o_ctrl.alu_op = ALU_ADD; end
               c_FN_SUB: begin o_ctrl.reg_write = 1'b1; o_ctrl.reg_dst = 1'b1; o_ctrl.alu_op = ALU_SUB; end
               c_FN_AND: begin o_ctrl.reg_write = 1'b1; o_ctrl.reg_dst = 1'b1; o_ctrl.alu_op = ALU_AND; end
               c_FN_OR:  begin o_ctrl.reg_write = 1'b1; o_ctrl.reg_dst = 1'b1; o_ctrl.alu_op = ALU_OR;  end
               c_FN_SLT: begin o_ctrl.reg_write = 1'b1; o_ctrl.reg_dst = 1'b1; o_ctrl.alu_op = ALU_SLT; end
               default: ;
            endcase
         end
         c_OP_ADDI: begin
            o_ctrl.reg_write = 1'b1;
            o_ctrl.alu_src   = 1'b1;
         end
         c_OP_LW: begin
            o_ctrl.reg_write  = 1'b1;
            o_ctrl.alu_src    = 1'b1;
            o_ctrl.mem_to_reg = 1'b1;
         end
         c_OP_SW: begin
            o_ctrl.alu_src   = 1'b1;
            o_ctrl.mem_write = 1'b1;
         end
         c_OP_BEQ: begin
            o_ctrl.branch = 1'b1;
            o_ctrl.alu_op = ALU_SUB;
         end
         c_OP_J: begin
            o_ctrl.jump = 1'b1;
         end
         default: ;
      endcase
   end
endmodule

module alu
   import mips_pkg::*;
(
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   input  alu_op_t     i_op,
   output logic [31:0] o_y,
   output logic        o_zero
);
   logic w_lt;
   assign w_lt = ($signed(i_a) < $signed(i_b));

   always_comb begin
      o_y = 32'd0;
      case (i_op)
         ALU_ADD: o_y = i_a + i_b;
         ALU_SUB: o_y = i_a - i_b;
         ALU_AND: o_y = i_a & i_b;
         ALU_OR:  o_y = i_a | i_b;
         ALU_SLT: o_y = {31'd0, w_lt};
         default: o_y = 32'd0;
      endcase
   end

   assign o_zero = (o_y == 32'd0);
endmodule
`default_nettype wire

// File: rtl/mips_processor_core.sv
`default_nettype none
// ============================================================================
//  Module      : mips_processor_core
//  Description : Single-cycle 32-bit MIPS core (add/sub/and/or/slt, addi,
//                lw, sw, beq, j). Fetch, decode, execute, memory and
//                writeback all complete in one clock. Memories are preloaded
//                and observed through u_instr_mem, u_reg_file and u_data_mem.
//  Ports       : clk - system clock, rising edge
//                rst - synchronous active-high reset (pc <= 0, writes blocked)
//  Revision    : 1.0  initial release
// ============================================================================
module mips_processor_core
   import mips_pkg::*;
#(
   parameter int IMEM_WORDS = 1024,
   parameter int DMEM_WORDS = 1024
) (
   input  logic clk,
   input  logic rst
);
   logic [31:0] r_pc;
   logic [31:0] w_instr;
   logic [31:0] w_pc_plus4;
   logic [31:0] w_pc_branch;
   logic [31:0] w_pc_jump;
   logic [31:0] w_pc_next;
   logic [31:0] w_imm_ext;
   logic [31:0] w_rd1;
   logic [31:0] w_rd2;
   logic [31:0] w_alu_b;
   logic [31:0] w_alu_y;
   logic        w_alu_zero;
   logic [31:0] w_mem_rdata;
   logic [31:0] w_wb_data;
   logic [4:0]  w_wb_addr;
   ctrl_t       w_ctrl;
   logic        w_unused;

   // Shamt is not used by any supported instruction.
   assign w_unused = &{1'b0, w_instr[10:6]};

   // ---------------------------------------------------------------- fetch
   always_ff @(posedge clk) begin
      if (rst) r_pc <= 32'd0;
      else     r_pc <= w_pc_next;
   end

   instr_mem #(.WORDS(IMEM_WORDS)) u_instr_mem (
      .clk     (clk),
      .i_we    (1'b0),
      .i_waddr (10'd0),
      .i_wdata (32'd0),
      .i_addr  (r_pc[11:2]),
      .o_data  (w_instr)
   );

   // --------------------------------------------------------------- decode
   control u_control (
      .i_opcode (w_instr[31:26]),
      .i_funct  (w_instr[5:0]),
      .o_ctrl   (w_ctrl)
   );

   assign w_imm_ext = sign_extend(w_instr[15:0]);
   assign w_wb_addr = w_ctrl.reg_dst ? w_instr[15:11] : w_instr[20:16];

   reg_file u_reg_file (
      .clk   (clk),
      .rst   (rst),
      .i_ra1 (w_instr[25:21]),
      .i_ra2 (w_instr[20:16]),
      .o_rd1 (w_rd1),
      .o_rd2 (w_rd2),
      .i_we  (w_ctrl.reg_write),
      .i_wa  (w_wb_addr),
      .i_wd  (w_wb_data)
   );

   // -------------------------------------------------------------- execute
   assign w_alu_b = w_ctrl.alu_src ? w_imm_ext : w_rd2;

   alu u_alu (
      .i_a    (w_rd1),
      .i_b    (w_alu_b),
      .i_op   (w_ctrl.alu_op),
      .o_y    (w_alu_y),
      .o_zero (w_alu_zero)
   );

   // --------------------------------------------------------------- memory
   // Only address bits [11:2] are used, so data accesses wrap at 4 KB and
   // the low two bits are ignored.
   data_mem #(.WORDS(DMEM_WORDS)) u_data_mem (
      .clk     (clk),
      .rst     (rst),
      .i_we    (w_ctrl.mem_write),
      .i_addr  (w_alu_y[11:2]),
      .i_wdata (w_rd2),
      .o_rdata (w_mem_rdata)
   );

   assign w_wb_data = w_ctrl.mem_to_reg ? w_mem_rdata : w_alu_y;

   // ------------------------------------------------------------- next pc
   assign w_pc_plus4  = r_pc + 32'd4;
   assign w_pc_branch = w_pc_plus4 + {w_imm_ext[29:0], 2'b00};
   assign w_pc_jump   = {w_pc_plus4[31:28], w_instr[25:0], 2'b00};

   always_comb begin
      w_pc_next = w_pc_plus4;
      if (w_ctrl.jump)                      w_pc_next = w_pc_jump;
      else if (w_ctrl.branch && w_alu_zero) w_pc_next = w_pc_branch;
   end

endmodule
`default_nettype wire

// File: tb/tb_mips_processor_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_processor_core
//  Description : Self-checking bench for mips_processor_core. Single-
//                instruction vectors from a table, plus short hand-written
//                programs for reset, I-type, R-type and memory sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mips_processor_core;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   mips_processor_core #(.IMEM_WORDS(1024), .DMEM_WORDS(1024)) dut (
      .clk (clk),
      .rst (rst)
   );

   int n_cmp = 0;
   int n_err = 0;

   localparam logic [31:0] c_NOP = 32'hFC00_0000;   // opcode 111111

   typedef struct {
      string       name;
      logic [31:0] instr;
      logic [4:0]  ra;
      logic [31:0] va;
      logic [4:0]  rb;
      logic [31:0] vb;
      logic [4:0]  cr;      // register to check
      logic [31:0] cv;      // its expected value
      logic [31:0] cpc;     // expected pc after one edge
   } vec_t;

   vec_t vecs[$];

   function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
      return {6'b000000, rs, rt, rd, 5'b00000, fn};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] enc_j(input logic [25:0] tgt);
      return {6'b000010, tgt};
   endfunction

   function automatic logic [31:0] sent(input int i);
      return (i == 0) ? 32'd0 : (32'hA500_0000 + 32'(i));
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic add_vec(input string nm, input logic [31:0] ins,
                          input logic [4:0] ra, input logic [31:0] va,
                          input logic [4:0] rb, input logic [31:0] vb,
                          input logic [4:0] cr, input logic [31:0] cv,
                          input logic [31:0] cpc);
      vec_t v;
      v.name = nm; v.instr = ins; v.ra = ra; v.va = va; v.rb = rb; v.vb = vb;
      v.cr = cr; v.cv = cv; v.cpc = cpc;
      vecs.push_back(v);
   endtask

   // Hold reset across an edge, then fill imem with nops and regs with
   // recognisable sentinels. Caller releases reset via run().
   task automatic begin_prog();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 1024; i++) dut.u_instr_mem.mem[i] = c_NOP;
      for (int i = 0; i < 32; i++)   dut.u_reg_file.regs[i] = sent(i);
   endtask

   task automatic run(input int n);
      rst = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) dut.u_data_mem.mem[i] = 32'd0;

      // ---------------------------------------------------- vector table
      add_vec("add",       enc_r(1, 2, 3, 6'b100000), 1, 32'd5,        2, 32'hFFFF_FFFF, 3, 32'd4,        32'd4);
      add_vec("sub_wrap",  enc_r(1, 2, 3, 6'b100010), 1, 32'd0,        2, 32'd1,         3, 32'hFFFF_FFFF, 32'd4);
      add_vec("and",       enc_r(1, 2, 3, 6'b100100), 1, 32'hF0F0_F0F0, 2, 32'hFF00_FF00, 3, 32'hF000_F000, 32'd4);
      add_vec("or",        enc_r(1, 2, 3, 6'b100101), 1, 32'hF0F0_F0F0, 2, 32'hFF00_FF00, 3, 32'hFFF0_FFF0, 32'd4);
      add_vec("slt_neg",   enc_r(1, 2, 3, 6'b101010), 1, 32'hFFFF_FFFF, 2, 32'd1,         3, 32'd1,        32'd4);
      add_vec("slt_ge",    enc_r(1, 2, 3, 6'b101010), 1, 32'd1,        2, 32'hFFFF_FFFF, 3, 32'd0,        32'd4);
      add_vec("addi_wrap", enc_i(6'b001000, 1, 3, 16'h0001), 1, 32'h7FFF_FFFF, 2, 32'd0, 3, 32'h8000_0000, 32'd4);
      add_vec("addi_sext", enc_i(6'b001000, 1, 3, 16'h8000), 1, 32'd0,  2, 32'd0,         3, 32'hFFFF_8000, 32'd4);
      add_vec("beq_taken", enc_i(6'b000100, 1, 2, 16'h0002), 1, 32'd1,  2, 32'd1,         3, sent(3),      32'd12);
      add_vec("beq_not",   enc_i(6'b000100, 1, 2, 16'h0002), 1, 32'd1,  2, 32'd2,         3, sent(3),      32'd4);
      add_vec("beq_back",  enc_i(6'b000100, 1, 2, 16'hFFFF), 1, 32'd9,  2, 32'd9,         3, sent(3),      32'd0);
      add_vec("jump",      enc_j(26'h10),                   1, 32'd1,  2, 32'd1,         3, sent(3),      32'h40);
      add_vec("unk_op",    {6'b111111, 5'd1, 5'd3, 16'd5},  1, 32'd1,  2, 32'd1,         3, sent(3),      32'd4);
      add_vec("unk_funct", enc_r(1, 2, 3, 6'b000001),       1, 32'd1,  2, 32'd1,         3, sent(3),      32'd4);
      add_vec("addi_r0",   enc_i(6'b001000, 0, 0, 16'd5),   1, 32'd1,  2, 32'd1,         0, 32'd0,        32'd4);
      add_vec("read_r0",   enc_r(0, 1, 3, 6'b100000),       0, 32'h1234, 1, 32'd7,       3, 32'd7,        32'd4);

      for (int k = 0; k < vecs.size(); k++) begin
         begin_prog();
         dut.u_instr_mem.mem[0] = vecs[k].instr;
         dut.u_reg_file.regs[vecs[k].ra] = vecs[k].va;
         dut.u_reg_file.regs[vecs[k].rb] = vecs[k].vb;
         run(1);
         chk({vecs[k].name, "_reg"}, dut.u_reg_file.regs[vecs[k].cr], vecs[k].cv);
         chk({vecs[k].name, "_pc"},  dut.r_pc, vecs[k].cpc);
      end

      // ---------------------------------------- reset hold / mid-program
      begin_prog();
      dut.u_instr_mem.mem[0] = enc_i(6'b001000, 8, 8, 16'd1);
      dut.u_reg_file.regs[8] = 32'h100;
      dut.u_data_mem.mem[7]  = 32'hCAFE_F00D;
      run(3);
      chk("pre_rst_pc", dut.r_pc, 32'd12);
      chk("pre_rst_r8", dut.u_reg_file.regs[8], 32'h101);
      rst = 1'b1;
      repeat (10) @(negedge clk);
      chk("rst_pc",    dut.r_pc, 32'd0);
      chk("rst_r8",    dut.u_reg_file.regs[8], 32'h101);
      chk("rst_dmem7", dut.u_data_mem.mem[7], 32'hCAFE_F00D);
      run(1);
      chk("post_rst_r8", dut.u_reg_file.regs[8], 32'h102);
      chk("post_rst_pc", dut.r_pc, 32'd4);

      // ---------------------------------------------------- I-type pair
      begin_prog();
      dut.u_instr_mem.mem[0] = enc_i(6'b001000, 8, 9, 16'd5);
      dut.u_instr_mem.mem[1] = enc_i(6'b001000, 9, 10, 16'hFFEC);
      dut.u_reg_file.regs[8] = 32'd10;
      run(2);
      chk("itype_r9",  dut.u_reg_file.regs[9],  32'd15);
      chk("itype_r10", dut.u_reg_file.regs[10], 32'hFFFF_FFFB);
      chk("itype_pc",  dut.r_pc, 32'd8);

      // ---------------------------------------------------- R-type run
      begin_prog();
      dut.u_instr_mem.mem[0] = enc_r(8, 9, 10, 6'b100000);
      dut.u_instr_mem.mem[1] = enc_r(8, 9, 11, 6'b100010);
      dut.u_instr_mem.mem[2] = enc_r(8, 9, 12, 6'b100100);
      dut.u_instr_mem.mem[3] = enc_r(8, 9, 13, 6'b100101);
      dut.u_instr_mem.mem[4] = enc_r(8, 9, 14, 6'b101010);
      dut.u_instr_mem.mem[5] = enc_r(9, 8, 15, 6'b101010);
      dut.u_reg_file.regs[8] = 32'd7;
      dut.u_reg_file.regs[9] = 32'd3;
      run(6);
      chk("rtype_add", dut.u_reg_file.regs[10], 32'd10);
      chk("rtype_sub", dut.u_reg_file.regs[11], 32'd4);
      chk("rtype_and", dut.u_reg_file.regs[12], 32'd3);
      chk("rtype_or",  dut.u_reg_file.regs[13], 32'd7);
      chk("rtype_slt0", dut.u_reg_file.regs[14], 32'd0);
      chk("rtype_slt1", dut.u_reg_file.regs[15], 32'd1);
      chk("rtype_pc",  dut.r_pc, 32'd24);

      // ---------------------------------------------------- memory
      begin_prog();
      dut.u_instr_mem.mem[0] = enc_i(6'b101011, 8, 9, 16'd4);       // sw $9,4($8)
      dut.u_instr_mem.mem[1] = enc_i(6'b100011, 8, 10, 16'd4);      // lw $10,4($8)
      dut.u_instr_mem.mem[2] = enc_i(6'b100011, 8, 11, 16'h1004);   // wraps to word 5
      dut.u_instr_mem.mem[3] = {6'b111111, 5'd8, 5'd12, 16'd0};     // unknown op
      dut.u_reg_file.regs[8] = 32'h10;
      dut.u_reg_file.regs[9] = 32'hDEAD_BEEF;
      dut.u_data_mem.mem[4]  = 32'h1111_1111;
      dut.u_data_mem.mem[5]  = 32'd0;
      run(4);
      chk("mem_dmem5", dut.u_data_mem.mem[5], 32'hDEAD_BEEF);
      chk("mem_dmem4", dut.u_data_mem.mem[4], 32'h1111_1111);
      chk("mem_lw",    dut.u_reg_file.regs[10], 32'hDEAD_BEEF);
      chk("mem_wrap",  dut.u_reg_file.regs[11], 32'hDEAD_BEEF);
      chk("mem_unk_r12", dut.u_reg_file.regs[12], sent(12));
      chk("mem_pc",    dut.r_pc, 32'd16);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
